// File: rtl/logic_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pkg
// Purpose  : Shared opcode/state types and helpers for logic_unit_pipe.
// Revision : 1.0 - initial release
// ============================================================================
package logic_unit_pkg;

    // Three-bit operation codes; the two top codes fold a burst of beats.
    typedef enum logic [2:0] {
        OP_AND     = 3'b000,
        OP_OR      = 3'b001,
        OP_XOR     = 3'b010,
        OP_NOR     = 3'b011,
        OP_ANDN    = 3'b100,
        OP_NAND    = 3'b101,
        OP_ACC_AND = 3'b110,
        OP_ACC_OR  = 3'b111
    } op_t;

    // Controller states: waiting for a first beat, or folding a burst.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // True for the opcodes that accumulate across several beats.
    function automatic logic is_fold(input op_t op);
        return (op == OP_ACC_AND) || (op == OP_ACC_OR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_unit_pipe_bitwise_op.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_op
// Purpose  : Combinational WIDTH-bit logic function selected by opcode.
//            Fold opcodes map onto their base AND/OR so the same block can
//            also serve as the accumulator combine step.
// Revision : 1.0 - initial release
// ============================================================================
module bitwise_op
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  op_t              i_op,
    output logic [WIDTH-1:0] o_y
);

    // Opcode-selected bitwise function.
    always_comb begin
        o_y = '0;
        case (i_op)
            OP_AND:     o_y = i_a & i_b;
            OP_OR:      o_y = i_a | i_b;
            OP_XOR:     o_y = i_a ^ i_b;
            OP_NOR:     o_y = ~(i_a | i_b);
            OP_ANDN:    o_y = i_a & ~i_b;
            OP_NAND:    o_y = ~(i_a & i_b);
            OP_ACC_AND: o_y = i_a & i_b;
            OP_ACC_OR:  o_y = i_a | i_b;
            default:    o_y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_pipe
// Purpose  : Registered WIDTH-bit logic unit with valid/ready on both sides,
//            single-beat ops plus AND/OR fold over a burst of operand pairs,
//            and zero / all-ones flags registered alongside the result.
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int  WIDTH     = 32,
    parameter int  MAX_BEATS = 16,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_all_ones,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_overflow
);

    state_t             r_state;
    op_t                r_op;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_all_ones;
    logic [CNT_W-1:0]   r_beats;
    logic               r_overflow;

    op_t                w_in_op;
    op_t                w_pair_op;
    logic [WIDTH-1:0]   w_pair;
    logic [WIDTH-1:0]   w_fold;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_start_burst;
    logic               w_load_en;
    logic [WIDTH-1:0]   w_load_val;
    logic [CNT_W-1:0]   w_load_beats;
    logic               w_load_ovf;

    assign w_in_op    = op_t'(in_op);
    // Later beats of a burst ignore in_op and reuse the latched fold op.
    assign w_pair_op  = (r_state == ACC) ? r_op : w_in_op;
    assign w_cnt_next = r_cnt + CNT_W'(1);
    // One result slot: accept when empty or when the slot drains this edge.
    assign in_ready   = !r_out_valid || out_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // Combine the incoming operand pair.
    bitwise_op #(.WIDTH(WIDTH)) u_pair (
        .i_a  (in_a),
        .i_b  (in_b),
        .i_op (w_pair_op),
        .o_y  (w_pair)
    );

    // Fold the combined pair into the running accumulator.
    bitwise_op #(.WIDTH(WIDTH)) u_fold (
        .i_a  (r_acc),
        .i_b  (w_pair),
        .i_op (r_op),
        .o_y  (w_fold)
    );

    // Decide whether this beat opens a burst or produces a result, and what.
    always_comb begin
        w_start_burst = 1'b0;
        w_load_en     = 1'b0;
        w_load_val    = w_pair;
        w_load_beats  = CNT_W'(1);
        w_load_ovf    = 1'b0;
        if (w_in_fire) begin
            if (r_state == IDLE) begin
                if (is_fold(w_in_op) && !in_last) begin
                    w_start_burst = 1'b1;
                end else begin
                    w_load_en = 1'b1;
                end
            end else if (in_last || (w_cnt_next == CNT_W'(MAX_BEATS))) begin
                // Burst closes on last, or is truncated at the beat limit.
                w_load_en    = 1'b1;
                w_load_val   = w_fold;
                w_load_beats = w_cnt_next;
                w_load_ovf   = !in_last;
            end
        end
    end

    // Controller FSM, accumulator and registered output bundle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_op        <= OP_AND;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_all_ones  <= 1'b0;
            r_beats     <= '0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_burst) begin
                        r_acc   <= w_pair;
                        r_cnt   <= CNT_W'(1);
                        r_op    <= w_in_op;
                        r_state <= ACC;
                    end
                end
                ACC: begin
                    if (w_in_fire) begin
                        if (w_load_en) begin
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_acc <= w_fold;
                            r_cnt <= w_cnt_next;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A new load takes priority so a same-edge swap leaves no bubble.
            if (w_load_en) begin
                r_out_valid <= 1'b1;
                r_result    <= w_load_val;
                r_zero      <= (w_load_val == '0);
                r_all_ones  <= (w_load_val == '1);
                r_beats     <= w_load_beats;
                r_overflow  <= w_load_ovf;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_result   = r_result;
    assign out_zero     = r_zero;
    assign out_all_ones = r_all_ones;
    assign out_beats    = r_beats;
    assign out_overflow = r_overflow;

endmodule
`default_nettype wire
